// File: rtl/ccff_chain_loader_if.sv
// Host-side and chain-side signal bundle for the ccff chain loader.
// The loader uses the slave view; the host/chain environment uses the master view.
interface ccff_chain_loader_if #(
   parameter int WORD_W = 8
);
   logic              start;
   logic              abort;
   logic [WORD_W-1:0] cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;
   logic              ccff_head;
   logic              ccff_shift_en;
   logic              ccff_tail;
   logic [WORD_W-1:0] rb_data;
   logic              rb_valid;
   logic              busy;
   logic              done;
   logic              err_overrun;

   modport slave (
      input  start, abort, cfg_data, cfg_valid, ccff_tail,
      output cfg_ready, ccff_head, ccff_shift_en, rb_data, rb_valid, busy, done, err_overrun
   );

   modport master (
      output start, abort, cfg_data, cfg_valid, ccff_tail,
      input  cfg_ready, ccff_head, ccff_shift_en, rb_data, rb_valid, busy, done, err_overrun
   );
endinterface

// File: rtl/ccff_chain_loader.sv
// Streams host words LSB-first into the ccff chain and returns the displaced
// chain contents as readback words.
module ccff_chain_loader #(
   parameter int WORD_W    = 8,
   parameter int CHAIN_LEN = 64,
   parameter int CNT_W     = 16
) (
   input  logic                prog_clk,
   input  logic                prog_reset_n,
   ccff_chain_loader_if.slave  cfg_if
);
   localparam int PW = $clog2(WORD_W);
   localparam int BW = $clog2(WORD_W + 1);
   localparam int AW = CNT_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [AW-1:0]     r_acc_bits;
   logic [WORD_W-1:0] r_buf;
   logic [BW-1:0]     r_buf_cnt;
   logic [WORD_W-1:0] r_rb_acc;
   logic [WORD_W-1:0] r_rb_data;
   logic [PW-1:0]     r_rb_pos;
   logic              r_rb_valid;
   logic              r_err_ovr;

   logic              w_shift_en;
   logic              w_ready;
   logic              w_go;
   logic              w_abort;
   logic              w_xfer;
   logic              w_bit_last;
   logic              w_word_end;
   logic              w_ovr;
   logic [WORD_W-1:0] w_rb_word;

   // State register
   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, shift enable and host handshake
   always_comb begin
      w_state_nxt = r_state;
      w_shift_en  = 1'b0;
      w_ready     = 1'b0;
      w_go        = 1'b0;
      w_abort     = 1'b0;
      w_bit_last  = (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (cfg_if.start && !cfg_if.abort) begin
               w_go        = 1'b1;
               w_state_nxt = ST_LOAD;
            end else begin
               w_state_nxt = r_state;
            end
         end
         ST_LOAD: begin
            w_shift_en = (r_buf_cnt != BW'(0)) && (r_bit_cnt < CNT_W'(CHAIN_LEN));
            // Refill as the last buffered bit leaves so words stream without a bubble
            w_ready    = (r_acc_bits < AW'(CHAIN_LEN)) &&
                         ((r_buf_cnt == BW'(0)) || ((r_buf_cnt == BW'(1)) && w_shift_en));
            if (cfg_if.abort) begin
               w_abort     = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (w_shift_en && w_bit_last) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_LOAD;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      w_xfer     = cfg_if.cfg_valid && w_ready;
      w_ovr      = cfg_if.cfg_valid && (r_state != ST_LOAD);
      w_word_end = (r_rb_pos == PW'(WORD_W - 1)) || w_bit_last;
      w_rb_word  = r_rb_acc;
      w_rb_word[r_rb_pos] = cfg_if.ccff_tail;
   end

   // Word buffer, bit counters and readback assembly
   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         r_bit_cnt  <= '0;
         r_acc_bits <= '0;
         r_buf      <= '0;
         r_buf_cnt  <= '0;
         r_rb_acc   <= '0;
         r_rb_pos   <= '0;
         r_rb_data  <= '0;
         r_rb_valid <= 1'b0;
      end else if (w_go || w_abort) begin
         r_bit_cnt  <= '0;
         r_acc_bits <= '0;
         r_buf      <= '0;
         r_buf_cnt  <= '0;
         r_rb_acc   <= '0;
         r_rb_pos   <= '0;
         r_rb_valid <= 1'b0;
      end else begin
         r_rb_valid <= w_shift_en && w_word_end;
         if (w_shift_en) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
         end
         if (w_xfer) begin
            r_buf      <= cfg_if.cfg_data;
            r_buf_cnt  <= BW'(WORD_W);
            r_acc_bits <= r_acc_bits + AW'(WORD_W);
         end else if (w_shift_en) begin
            r_buf     <= r_buf >> 1;
            r_buf_cnt <= r_buf_cnt - BW'(1);
         end
         // Final partial word leaves with its unfilled MSBs still zero
         if (w_shift_en && w_word_end) begin
            r_rb_data <= w_rb_word;
            r_rb_acc  <= '0;
            r_rb_pos  <= '0;
         end else if (w_shift_en) begin
            r_rb_acc  <= w_rb_word;
            r_rb_pos  <= r_rb_pos + PW'(1);
         end
      end
   end

   // Sticky overrun flag: host offered data with no load in progress
   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         r_err_ovr <= 1'b0;
      end else if (w_ovr) begin
         r_err_ovr <= 1'b1;
      end else if (w_go) begin
         r_err_ovr <= 1'b0;
      end
   end

   assign cfg_if.cfg_ready     = w_ready;
   assign cfg_if.ccff_shift_en = w_shift_en;
   assign cfg_if.ccff_head     = w_shift_en & r_buf[0];
   assign cfg_if.rb_data       = r_rb_data;
   assign cfg_if.rb_valid      = r_rb_valid;
   assign cfg_if.busy          = (r_state == ST_LOAD);
   assign cfg_if.done          = (r_state == ST_DONE);
   assign cfg_if.err_overrun   = r_err_ovr;
endmodule
